debounce_bank: RTL and testbench

Parametrised multi-channel push-button/switch conditioner for the board-level I/O of the FPGA design. Each channel synchronises an asynchronous raw input into the `clk` domain and filters it with a tick-counted stability window. It presents a clean level plus single-cycle press/release pulses to the processor's memory-mapped I/O and the control logic. It replaces fixed three-flop debouncing on a divided clock with a single system clock and a clock-enable `tick`, with optional auto-repeat.

---
 rtl/debounce_bank.sv | 106 ++++++++++
 tb/tb_debounce_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel synchroniser plus tick-counted stability filter.
// Optional auto-repeat on held buttons when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank #(
    parameter int N           = 4,
    parameter int STABLE      = 8,
    parameter int CNT_W       = 8,
    parameter int REPEAT_DLY  = 100,
    parameter int REPEAT_RATE = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] pb_press,
    output logic [N-1:0] pb_release,
    output logic         any_press
);

    localparam logic [CNT_W-1:0] LP_STB_LAST = CNT_W'(STABLE - 1);

    logic [N-1:0] r_s0;
    logic [N-1:0] r_s1;
    logic [N-1:0] r_level;
    logic [N-1:0] r_press;
    logic [N-1:0] r_release;
    logic [N-1:0] w_acc;
    logic [N-1:0] w_rpt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0      <= '0;
            r_s1      <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_s0      <= pb_in;
            r_s1      <= r_s0;
            r_level   <= r_level ^ w_acc;
            r_press   <= (w_acc & r_s1) | w_rpt;
            r_release <= w_acc & ~r_s1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;

        assign w_diff   = r_s1[g] != r_level[g];
        assign w_acc[g] = w_diff && tick && (r_cnt == LP_STB_LAST);

        // Any cycle where the input agrees with the level discards progress
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (!w_diff) begin
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == LP_STB_LAST) r_cnt <= '0;
                else                      r_cnt <= r_cnt + 1'b1;
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam logic [CNT_W-1:0] LP_DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
        localparam logic [CNT_W-1:0] LP_RATE_LAST = CNT_W'(REPEAT_RATE - 1);

        logic [CNT_W-1:0] r_rpt;
        logic             r_armed;
        logic             w_hold;
        logic             w_rpt_hit;

        assign w_hold    = r_level[g] & r_s1[g];
        assign w_rpt_hit = r_armed ? (r_rpt == LP_RATE_LAST)
                                   : (r_rpt == LP_DLY_LAST);
        assign w_rpt[g]  = w_hold & tick & w_rpt_hit;

        // r_armed selects the initial delay versus the steady repeat rate
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rpt   <= '0;
                r_armed <= 1'b0;
            end else if (!w_hold) begin
                r_rpt   <= '0;
                r_armed <= 1'b0;
            end else if (tick) begin
                if (w_rpt_hit) begin
                    r_rpt   <= '0;
                    r_armed <= 1'b1;
                end else begin
                    r_rpt <= r_rpt + 1'b1;
                end
            end
        end
`else
        assign w_rpt[g] = 1'b0;
`endif
    end

    assign pb_level   = r_level;
    assign pb_press   = r_press;
    assign pb_release = r_release;
    assign any_press  = |r_press;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed stimulus with a cycle-stamped event scoreboard.
// Repeat expectations are added when DEBOUNCE_REPEAT_EN is defined.
module tb_debounce_bank;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] pb_in;
    logic [3:0] pb_level;
    logic [3:0] pb_press;
    logic [3:0] pb_release;
    logic       any_press;

    exp_t       exp_q[$];
    int         cyc     = 0;
    int         n_total = 0;
    int         n_pass  = 0;
    bit         gate    = 1'b0;
    logic [3:0] mdl_lvl = 4'b0000;

    debounce_bank #(
        .N          (4),
        .STABLE     (4),
        .CNT_W      (8),
        .REPEAT_DLY (10),
        .REPEAT_RATE(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .pb_in     (pb_in),
        .pb_level  (pb_level),
        .pb_press  (pb_press),
        .pb_release(pb_release),
        .any_press (any_press)
    );

    always #5 clk = ~clk;

    task automatic push(input int c, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    endtask

    task automatic upd_tick();
        tick = gate ? ((cyc + 1) % 10 == 0) : 1'b1;
    endtask

    task automatic step();
        exp_t       e;
        logic [3:0] ep;
        logic [3:0] er;
        @(posedge clk);
        cyc++;
        #1;
        ep = 4'b0000;
        er = 4'b0000;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e       = exp_q.pop_front();
            ep      = e.press;
            er      = e.rel;
            mdl_lvl = e.lvl;
        end
        chk("press", pb_press, ep);
        chk("release", pb_release, er);
        chk("level", pb_level, mdl_lvl);
        chk("any_press", {3'b000, any_press}, {3'b000, |ep});
        upd_tick();
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        pb_in = 4'b0000;
        tick  = 1'b1;

        goto(3);
        rst_n = 1'b1;

        // clean press / release on channel 0
        goto(10);
        pb_in[0] = 1'b1;
        push(16, 4'b0001, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_REPEAT_EN
        push(26, 4'b0001, 4'b0000, 4'b0001);
        push(31, 4'b0001, 4'b0000, 4'b0001);
`endif
        goto(30);
        pb_in[0] = 1'b0;
        push(36, 4'b0000, 4'b0001, 4'b0000);

        // bounce on channel 1, settles high
        goto(45); pb_in[1] = 1'b1;
        goto(47); pb_in[1] = 1'b0;
        goto(49); pb_in[1] = 1'b1;
        goto(51); pb_in[1] = 1'b0;
        goto(53); pb_in[1] = 1'b1;
        push(59, 4'b0010, 4'b0000, 4'b0010);
`ifdef DEBOUNCE_REPEAT_EN
        push(69, 4'b0010, 4'b0000, 4'b0010);
`endif
        goto(70);
        pb_in[1] = 1'b0;
        push(76, 4'b0000, 4'b0010, 4'b0000);

        // tick every 10 clocks: glitch rejected, hold accepted on 4th tick
        goto(85);
        gate = 1'b1;
        upd_tick();
        goto(91);
        pb_in[2] = 1'b1;
        goto(116);
        pb_in[2] = 1'b0;
        goto(131);
        pb_in[2] = 1'b1;
        push(170, 4'b0100, 4'b0000, 4'b0100);
        goto(180);
        pb_in[2] = 1'b0;
        push(220, 4'b0000, 4'b0100, 4'b0000);
        goto(225);
        gate = 1'b0;
        upd_tick();

        // simultaneous channels
        goto(230);
        pb_in = 4'b1011;
        push(236, 4'b1011, 4'b0000, 4'b1011);
`ifdef DEBOUNCE_REPEAT_EN
        push(246, 4'b1011, 4'b0000, 4'b1011);
        push(251, 4'b1011, 4'b0000, 4'b1011);
        push(256, 4'b1011, 4'b0000, 4'b1011);
        push(261, 4'b1011, 4'b0000, 4'b1011);
`endif
        goto(260);
        pb_in = 4'b0000;
        push(266, 4'b0000, 4'b1011, 4'b0000);

        // reset while channel 2 is part-way through its window
        goto(280);
        pb_in[2] = 1'b1;
        goto(284);
        rst_n = 1'b0;
        goto(287);
        rst_n = 1'b1;
        push(293, 4'b0100, 4'b0000, 4'b0100);
`ifdef DEBOUNCE_REPEAT_EN
        push(303, 4'b0100, 4'b0000, 4'b0100);
        push(308, 4'b0100, 4'b0000, 4'b0100);
        push(313, 4'b0100, 4'b0000, 4'b0100);
        push(318, 4'b0100, 4'b0000, 4'b0100);
`endif
        goto(320);
        pb_in[2] = 1'b0;
        push(326, 4'b0000, 4'b0100, 4'b0000);
        goto(340);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL pending_events got=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
